// File: rtl/fixed_divide_seq_pkg.sv
// Shared types and helpers for the sequential fixed-point divider.
// Limit and magnitude helpers work on 64-bit words; callers truncate to their own width.
package fixed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Largest positive value of an n-bit two's-complement word.
    function automatic logic [63:0] sat_pos_mag(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    // Magnitude of the most negative n-bit value; its bit pattern is also that value.
    function automatic logic [63:0] sat_neg_mag(input int n);
        return 64'd1 << (n - 1);
    endfunction

    // Magnitude of a sign-extended word.
    function automatic logic [63:0] abs_mag(input logic [63:0] x);
        return x[63] ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/fixed_divide_seq_if.sv
// Operand/result handshake bundle for fixed_divide_seq.
interface fixed_divide_seq_if #(
    parameter int width_H = 5,
    parameter int width_W = 20
);
    localparam int N = width_H + width_W;

    logic         data_i_en;
    logic [N-1:0] data_i;
    logic [N-1:0] div_i;
    logic         ready_o;
    logic         data_o_en;
    logic [N-1:0] data_o;
    logic         ovf_o;
    logic         dz_o;

    modport master (
        output data_i_en, data_i, div_i,
        input  ready_o, data_o_en, data_o, ovf_o, dz_o
    );

    modport slave (
        input  data_i_en, data_i, div_i,
        output ready_o, data_o_en, data_o, ovf_o, dz_o
    );
endinterface

// File: rtl/fixed_divide_seq_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per clock, QB iterations.
// Quotient bits shift into the low end of the dividend register as it empties.
module divide_core #(
    parameter int N  = 25,
    parameter int QB = 45
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [QB-1:0] dvd_i,
    input  logic [N-1:0]  div_i,
    output logic          done_o,
    output logic [QB-1:0] quot_o
);
    localparam int CW = $clog2(QB);

    logic [N-1:0]  rem_r;
    logic [N-1:0]  div_r;
    logic [QB-1:0] dvd_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;

    logic [N:0]    shifted_s;
    logic [N:0]    trial_s;
    logic          qbit_s;
    logic          last_s;

    // Trial subtraction; remainder < divisor <= 2^(N-1), so N+1 bits never wrap.
    always_comb begin
        shifted_s = {rem_r, dvd_r[QB-1]};
        trial_s   = shifted_s - {1'b0, div_r};
        qbit_s    = ~trial_s[N];
        last_s    = busy_r && (cnt_r == CW'(QB - 1));
    end

    // Iteration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r  <= {N{1'b0}};
            div_r  <= {N{1'b0}};
            dvd_r  <= {QB{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
        end else if (start_i) begin
            rem_r  <= {N{1'b0}};
            div_r  <= div_i;
            dvd_r  <= dvd_i;
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b1;
        end else if (busy_r) begin
            rem_r <= qbit_s ? trial_s[N-1:0] : shifted_s[N-1:0];
            dvd_r <= {dvd_r[QB-2:0], qbit_s};
            if (last_s) begin
                busy_r <= 1'b0;
                cnt_r  <= {CW{1'b0}};
            end else begin
                cnt_r  <= cnt_r + CW'(1);
            end
        end
    end

    assign done_o = last_s;
    assign quot_o = dvd_r;

endmodule

// File: rtl/fixed_divide_seq.sv
// Signed Q(width_H).(width_W) sequential divider with saturation and divide-by-zero flag.
// Wraps the unsigned core with sign handling and the IDLE/CALC/FIN handshake FSM.
module fixed_divide_seq
    import fixed_pkg::*;
#(
    parameter int width_H = 5,
    parameter int width_W = 20
) (
    input logic               clk,
    input logic               rst,
    fixed_divide_seq_if.slave bus
);
    localparam int N  = width_H + width_W;
    localparam int QB = N + width_W;

    localparam logic [N-1:0]  POS_LIM   = N'(sat_pos_mag(N));
    localparam logic [N-1:0]  NEG_LIM   = N'(sat_neg_mag(N));
    localparam logic [QB-1:0] POS_MAG_Q = QB'(sat_pos_mag(N));
    localparam logic [QB-1:0] NEG_MAG_Q = QB'(sat_neg_mag(N));

    state_t        state_r;
    state_t        state_nxt_s;
    logic          start_s;
    logic          core_done_s;

    logic [N-1:0]  dvd_mag_s;
    logic [N-1:0]  div_mag_s;
    logic [QB-1:0] dvd_load_s;
    logic [QB-1:0] quot_s;

    logic          sign_r;
    logic          data_neg_r;
    logic          dz_lat_r;

    logic [N-1:0]  res_s;
    logic          res_ovf_s;
    logic          res_dz_s;

    logic          ready_r;
    logic          data_o_en_r;
    logic [N-1:0]  data_o_r;
    logic          ovf_r;
    logic          dz_r;

    // Operand magnitudes; -2^(N-1) maps to the unsigned value 2^(N-1).
    always_comb begin
        dvd_mag_s  = N'(abs_mag({{(64-N){bus.data_i[N-1]}}, bus.data_i}));
        div_mag_s  = N'(abs_mag({{(64-N){bus.div_i[N-1]}}, bus.div_i}));
        dvd_load_s = {{(QB-N){1'b0}}, dvd_mag_s} << width_W;
    end

    divide_core #(
        .N  (N),
        .QB (QB)
    ) divide_core_u (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_s),
        .dvd_i   (dvd_load_s),
        .div_i   (div_mag_s),
        .done_o  (core_done_s),
        .quot_o  (quot_s)
    );

    // Next-state logic; operands are only taken while idle.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.data_i_en) begin
                    start_s     = 1'b1;
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (core_done_s) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sign bookkeeping captured with the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r     <= 1'b0;
            data_neg_r <= 1'b0;
            dz_lat_r   <= 1'b0;
        end else if (start_s) begin
            sign_r     <= bus.data_i[N-1] ^ bus.div_i[N-1];
            data_neg_r <= bus.data_i[N-1];
            dz_lat_r   <= (bus.div_i == {N{1'b0}});
        end
    end

    // Re-sign the quotient magnitude, saturating when it exceeds the range for its sign.
    always_comb begin
        res_s     = {N{1'b0}};
        res_ovf_s = 1'b0;
        res_dz_s  = 1'b0;
        if (dz_lat_r) begin
            res_s    = data_neg_r ? NEG_LIM : POS_LIM;
            res_dz_s = 1'b1;
        end else if (sign_r && (quot_s > NEG_MAG_Q)) begin
            res_s     = NEG_LIM;
            res_ovf_s = 1'b1;
        end else if (!sign_r && (quot_s > POS_MAG_Q)) begin
            res_s     = POS_LIM;
            res_ovf_s = 1'b1;
        end else if (sign_r) begin
            res_s = {N{1'b0}} - quot_s[N-1:0];
        end else begin
            res_s = quot_s[N-1:0];
        end
    end

    // Registered outputs; the result is held until the next FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r     <= 1'b1;
            data_o_en_r <= 1'b0;
            data_o_r    <= {N{1'b0}};
            ovf_r       <= 1'b0;
            dz_r        <= 1'b0;
        end else begin
            ready_r     <= (state_nxt_s == IDLE);
            data_o_en_r <= (state_r == FIN);
            if (state_r == FIN) begin
                data_o_r <= res_s;
                ovf_r    <= res_ovf_s;
                dz_r     <= res_dz_s;
            end
        end
    end

    assign bus.ready_o   = ready_r;
    assign bus.data_o_en = data_o_en_r;
    assign bus.data_o    = data_o_r;
    assign bus.ovf_o     = ovf_r;
    assign bus.dz_o      = dz_r;

endmodule

// File: tb/tb_fixed_divide_seq.sv
// Directed-vector bench for fixed_divide_seq (Q5.20, 1.0 = 1048576).
module tb_fixed_divide_seq;
    localparam int N = 25;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    fixed_divide_seq_if #(.width_H(5), .width_W(20)) bus ();

    fixed_divide_seq #(.width_H(5), .width_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic start_op(input int a, input int b);
        @(negedge clk);
        bus.data_i_en = 1'b1;
        bus.data_i    = a[N-1:0];
        bus.div_i     = b[N-1:0];
        @(posedge clk);
        #1;
        bus.data_i_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.data_o_en) break;
        end
        if (!bus.data_o_en) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_res(input string tag, input int exp_q, input logic exp_ovf, input logic exp_dz);
        logic [N-1:0] e;
        e = exp_q[N-1:0];
        check({tag, "_q"}, {39'd0, bus.data_o}, {39'd0, e});
        check({tag, "_ovf"}, {63'd0, bus.ovf_o}, {63'd0, exp_ovf});
        check({tag, "_dz"}, {63'd0, bus.dz_o}, {63'd0, exp_dz});
        check({tag, "_rdy"}, {63'd0, bus.ready_o}, 64'd1);
    endtask

    task automatic run_div(input string tag, input int a, input int b, input int exp_q,
                           input logic exp_ovf, input logic exp_dz);
        int lat;
        start_op(a, b);
        check({tag, "_busy"}, {63'd0, bus.ready_o}, 64'd0);
        wait_done(tag, lat);
        check({tag, "_lat"}, 64'(lat), 64'd46);
        check_res(tag, exp_q, exp_ovf, exp_dz);
        @(posedge clk);
        #1;
        check({tag, "_pulse1"}, {63'd0, bus.data_o_en}, 64'd0);
        check({tag, "_hold"}, {39'd0, bus.data_o}, {39'd0, exp_q[N-1:0]});
    endtask

    initial begin
        int lat;
        int pulses;
        n_cmp = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.data_i_en = 1'b0;
        bus.data_i    = '0;
        bus.div_i     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {63'd0, bus.ready_o}, 64'd1);
        check("rst_en", {63'd0, bus.data_o_en}, 64'd0);
        check("rst_q", {39'd0, bus.data_o}, 64'd0);
        check("rst_flags", {62'd0, bus.ovf_o, bus.dz_o}, 64'd0);

        run_div("3_div_1p5", 3145728, 1572864, 2097152, 1'b0, 1'b0);
        run_div("1_div_3", 1048576, 3145728, 349525, 1'b0, 1'b0);
        run_div("m1_div_4", -1048576, 4194304, -262144, 1'b0, 1'b0);
        run_div("m1_div_3", -1048576, 3145728, -349525, 1'b0, 1'b0);
        run_div("0_div_m1", 0, -1048576, 0, 1'b0, 1'b0);
        run_div("15_div_q", 15728640, 262144, 16777215, 1'b1, 1'b0);
        run_div("m16_div_m1", -16777216, -1048576, 16777215, 1'b1, 1'b0);
        run_div("m16_div_1", -16777216, 1048576, -16777216, 1'b0, 1'b0);
        run_div("5_div_0", 5242880, 0, 16777215, 1'b0, 1'b1);
        run_div("m5_div_0", -5242880, 0, -16777216, 1'b0, 1'b1);

        // Strobe while busy must be dropped.
        start_op(3145728, 1572864);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.data_i_en = 1'b1;
        bus.data_i    = 25'd1048576;
        bus.div_i     = 25'd4194304;
        @(posedge clk);
        #1;
        bus.data_i_en = 1'b0;
        wait_done("ign", lat);
        check("ign_lat", 64'(lat), 64'd35);
        check_res("ign", 2097152, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("ign_no_2nd", {63'd0, bus.ready_o}, 64'd1);

        // Back-to-back: new op issued in the data_o_en cycle.
        start_op(1048576, 3145728);
        wait_done("b2b1", lat);
        check_res("b2b1", 349525, 1'b0, 1'b0);
        bus.data_i_en = 1'b1;
        bus.data_i    = 25'd15728640;
        bus.div_i     = 25'd262144;
        @(posedge clk);
        #1;
        bus.data_i_en = 1'b0;
        check("b2b_accept", {63'd0, bus.ready_o}, 64'd0);
        wait_done("b2b2", lat);
        check("b2b_gap", 64'(lat + 1), 64'd47);
        check_res("b2b2", 16777215, 1'b1, 1'b0);

        // Reset mid-CALC aborts without a result pulse.
        start_op(3145728, 1572864);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", {63'd0, bus.ready_o}, 64'd1);
        check("abort_en", {63'd0, bus.data_o_en}, 64'd0);
        check("abort_q", {39'd0, bus.data_o}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.data_o_en) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'd0);

        run_div("after_abort", -1048576, 4194304, -262144, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
